param_fifo: RTL and testbench
=============================

# param_fifo

Parametrised synchronous FIFO, the successor to the fixed 8-bit, 4-entry FIFO used between pipeline stages in the datapath. It adds configurable data width and arbitrary depth, a first-word-fall-through (FWFT) read mode, occupancy count output, programmable almost-full and almost-empty thresholds, and sticky overflow and underflow error flags. It sits in the same places as the current FIFO: stage decoupling and rate matching inside one clock domain.

## Interface
- `DATA_W`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of entries, ≥2; need not be a power of two.
- `FWFT`, 0: 0 selects standard read mode, 1 selects first-word-fall-through.
- `AFULL_TH`, DEPTH-1: almost_full asserts when count ≥ AFULL_TH; range 1..DEPTH.
- `AEMPTY_TH`, 1: almost_empty asserts when count ≤ AEMPTY_TH; range 0..DEPTH-1.
- Derived: `PTR_W` = max(1, $clog2(DEPTH)); `CNT_W` = $clog2(DEPTH+1).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push request.
- `wr_data` in DATA_W: push data.
- `rd_en` in 1: pop request. In FWFT mode this is the acknowledge of the current head.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `rd_data` out DATA_W: read data.
- `rd_valid` out 1: rd_data qualifier.
- `full`, `empty`, `almost_full`, `almost_empty` out 1: registered status flags.
- `count` out CNT_W: current occupancy, 0..DEPTH.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- Acceptance rules:
  - wr_ok = wr_en & (~full | rd_ok).
  - rd_ok = rd_en & ~empty.
  - A write to a full FIFO with a simultaneous read is accepted: count is unchanged and both pointers advance.
  - A read from an empty FIFO is never accepted, even with a simultaneous write.
- Rejected requests:
  - A rejected write (wr_en & ~wr_ok) drops the data and sets overflow.
  - A rejected read (rd_en & ~rd_ok) sets underflow.
  - No state other than the error flag changes.
- Pointers: wr_ptr and rd_ptr are PTR_W bits and advance on wr_ok and rd_ok respectively. They wrap from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- count_next = count + wr_ok − rd_ok, computed at CNT_W bits. It never leaves the range 0..DEPTH.
- Flags are registered from count_next:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - almost_full = (count_next ≥ AFULL_TH)
  - almost_empty = (count_next ≤ AEMPTY_TH)
- Standard mode (FWFT=0):
  - On rd_ok, rd_data is loaded with mem[rd_ptr] and rd_valid pulses high for one cycle.
  - Otherwise rd_data holds its value and rd_valid is 0.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty.
  - rd_en pops the displayed word.
  - rd_data is undefined while empty.
- Error flags:
  - overflow and underflow stay set until clr_err.
  - If clr_err and a new error occur in the same cycle, the error wins (the flag stays 1).
- Reset values, applied asynchronously when rst = 0:
  - count = 0, empty = 1, full = 0, almost_full = 0, almost_empty = 1.
  - rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0, both pointers = 0.
  - Storage is not reset.
- Reset asserted mid-operation discards all contents. After reset release the FIFO behaves as freshly empty.

## Timing
- Write to read availability:
  - A word written in cycle N is visible as the head (FWFT) or poppable (standard) from cycle N+1.
  - empty deasserts at N+1.
- Standard read latency is 1: rd_en accepted at N means rd_data and rd_valid are valid at N+1.
- FWFT read latency is 0 relative to the head. After a pop at N, the next word shows at N+1.
- All flags and count update one cycle after the accepted operation. There is no combinational path from wr_en or rd_en to any status output.
- The error flag is set in the cycle after the rejected request.

## Structure
- Package `fifo_pkg` holds:
  - the `fifo_mode_e` enum (FIFO_STD, FIFO_FWFT), used for documentation and for the bench;
  - a `fifo_status_t` packed struct {full, empty, almost_full, almost_empty, overflow, underflow} used by the bench monitor.
- Sub-module `param_fifo_mem` is the DEPTH×DATA_W storage array:
  - one synchronous write port;
  - one asynchronous read port;
  - no reset.
- Pointer, count, flag and error logic live in `param_fifo`.
- The cover properties on count (every value 0..DEPTH) and the stimulus assumptions (no write when full, no read when empty) are kept only in a bench-side bind file. The overflow and underflow paths must stay reachable in the error tests.

## Test plan
- Fill and drain:
  - Config: DEPTH=4, DATA_W=8, FWFT=0.
  - Stimulus: write 0x11,0x22,0x33,0x44, then four reads.
  - Response: full = 1 after the fourth write; reads return 0x11..0x44, each one cycle after rd_en; then empty = 1 and count = 0.
- Overflow and clear:
  - Stimulus: with the FIFO full, write 0x55 with no read, then assert clr_err.
  - Response: overflow = 1 and is cleared by clr_err; count stays 4; the drained data contains no 0x55.
- Simultaneous access at both boundaries:
  - Full with wr_en and rd_en together: both accepted, count stays 4, the head pops, and the new word lands in order.
  - Empty with wr_en and rd_en together: the write is accepted, underflow = 1, count = 1.
- FWFT mode:
  - Config: FWFT=1.
  - Stimulus: write 0xA5 at cycle N.
  - Response: rd_valid = 1 and rd_data = 0xA5 at N+1 without rd_en; rd_en at N+1 gives empty = 1 at N+2.
- Thresholds and wrap:
  - Config: DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
  - Stimulus: stream 12 words with interleaved reads.
  - Response: almost flags track count exactly; pointers wrap 4 to 0; data order is preserved.
- Asynchronous reset mid-stream:
  - Stimulus: with count = 3, assert rst between clock edges.
  - Response: empty = 1, count = 0 and rd_valid = 0 immediately; the first write after release is read back first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO and its bench.
package fifo_pkg;

    // Read-mode selector, mirrors the FWFT parameter value.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Snapshot of every status/error flag, in a fixed order.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width: at least one bit even for tiny depths.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous
// read port, no reset (contents are don't-care until written).
module param_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    localparam int PTR_W    = ptr_width(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_TH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              afull_q, afull_d, aempty_q, aempty_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_rdata_s;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ok_s, rd_ok_s;

    // Acceptance: a pop needs data; a push needs room or a concurrent pop.
    always_comb begin
        rd_ok_s = rd_en & ~empty_q;
        wr_ok_s = wr_en & (~full_q | rd_ok_s);
    end

    // Pointer advance with explicit wrap so any DEPTH works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Occupancy, status flags derived from the next count, sticky errors.
    always_comb begin
        count_d  = count_q + CNT_W'(wr_ok_s) - CNT_W'(rd_ok_s);
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_AF);
        aempty_d = (count_d <= CNT_AE);
        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d    = (wr_en & ~wr_ok_s) | (ovf_q & ~clr_err);
        udf_d    = (rd_en & ~rd_ok_s) | (udf_q & ~clr_err);
    end

    // Standard-mode read register: load on pop, otherwise hold.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_ok_s) begin
            rd_data_d  = mem_rdata_s;
            rd_valid_d = 1'b1;
        end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
    end

    // State registers; reset empties the FIFO but leaves storage alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    param_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_ok_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_s)
    );

    // FWFT shows the head directly; standard mode uses the read register.
    assign rd_data      = (FWFT != 0) ? mem_rdata_s : rd_data_q;
    assign rd_valid     = (FWFT != 0) ? ~empty_q    : rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: three configurations (standard depth 4, FWFT depth 4,
// standard depth 5 with thresholds 4/1). A queue model predicts contents and
// flags; popped words go to a scoreboard checked by a separate monitor.
module tb_param_fifo;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en   [3];
    logic [7:0] wr_data [3];
    logic       rd_en   [3];
    logic       clr_err [3];
    logic [7:0] rd_data [3];
    logic       rd_valid[3];
    logic       full    [3];
    logic       empty   [3];
    logic       afull   [3];
    logic       aempty  [3];
    logic [2:0] count   [3];
    logic       ovf     [3];
    logic       udf     [3];

    logic [7:0] mdl   [3][$];
    logic [7:0] exp_q [3][$];
    logic       m_ovf [3];
    logic       m_udf [3];
    logic       acc_rd[3];
    logic       vld_pipe[3];
    int         total;
    int         bad;

    param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .clr_err(clr_err[0]), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(afull[0]), .almost_empty(aempty[0]), .count(count[0]),
        .overflow(ovf[0]), .underflow(udf[0]));

    param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .clr_err(clr_err[1]), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(afull[1]), .almost_empty(aempty[1]), .count(count[1]),
        .overflow(ovf[1]), .underflow(udf[1]));

    param_fifo #(.DATA_W(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1)) u_th (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .clr_err(clr_err[2]), .rd_data(rd_data[2]),
        .rd_valid(rd_valid[2]), .full(full[2]), .empty(empty[2]),
        .almost_full(afull[2]), .almost_empty(aempty[2]), .count(count[2]),
        .overflow(ovf[2]), .underflow(udf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int i);
        return (i == 2) ? 5 : 4;
    endfunction
    function automatic int af_th(input int i);
        return (i == 2) ? 4 : 3;
    endfunction
    function automatic bit is_fwft(input int i);
        return (i == 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Compare one instance's flags and count with the model (after an edge).
    task automatic chk(input int i);
        fifo_status_t es, as;
        int n;
        n = mdl[i].size();
        es.full         = (n == dep(i));
        es.empty        = (n == 0);
        es.almost_full  = (n >= af_th(i));
        es.almost_empty = (n <= 1);
        es.overflow     = m_ovf[i];
        es.underflow    = m_udf[i];
        as = '{full[i], empty[i], afull[i], aempty[i], ovf[i], udf[i]};
        check($sformatf("status[%0d]", i), 32'(as), 32'(es));
        check($sformatf("count[%0d]", i), 32'(count[i]), n);
        if (is_fwft(i)) begin
            check("fwft_valid", 32'(rd_valid[i]), 32'(n != 0));
            if (n != 0) check("fwft_head", 32'(rd_data[i]), 32'(mdl[i][0]));
        end
    endtask

    // Drive one cycle of requests on instance i, update the model, check.
    task automatic step(input int i, input logic we, input logic [7:0] d,
                        input logic re, input logic ce);
        logic ra, wa;
        logic [7:0] v;
        ra = re && (mdl[i].size() != 0);
        wa = we && ((mdl[i].size() < dep(i)) || ra);
        wr_en[i] = we; wr_data[i] = d; rd_en[i] = re; clr_err[i] = ce;
        acc_rd[i] = ra;
        if (ra) begin
            v = mdl[i].pop_front();
            exp_q[i].push_back(v);
        end
        if (wa) mdl[i].push_back(d);
        m_ovf[i] = (we && !wa) || (m_ovf[i] && !ce);
        m_udf[i] = (re && !ra) || (m_udf[i] && !ce);
        @(posedge clk); #1;
        wr_en[i] = 1'b0; wr_data[i] = 8'h00; rd_en[i] = 1'b0; clr_err[i] = 1'b0;
        acc_rd[i] = 1'b0;
        chk(i);
    endtask

    task automatic clear_models();
        for (int i = 0; i < 3; i++) begin
            mdl[i].delete();
            exp_q[i].delete();
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
            acc_rd[i] = 1'b0;
        end
    endtask

    // Monitor: pop the scoreboard whenever a DUT presents a word.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) vld_pipe[i] = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!is_fwft(i)) begin
                    check($sformatf("rd_valid_lat[%0d]", i), 32'(rd_valid[i]), 32'(vld_pipe[i]));
                    if (rd_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            total++; bad++;
                            $display("FAIL sb_underrun[%0d]: got %0h expected none", i, rd_data[i]);
                        end else begin
                            check($sformatf("rd_data[%0d]", i), 32'(rd_data[i]), 32'(exp_q[i].pop_front()));
                        end
                    end
                    vld_pipe[i] = acc_rd[i];
                end else if (rd_en[i] && rd_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_underrun[%0d]: got %0h expected none", i, rd_data[i]);
                    end else begin
                        check("fwft_pop", 32'(rd_data[i]), 32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0; wr_data[i] = 8'h00; rd_en[i] = 1'b0; clr_err[i] = 1'b0;
            vld_pipe[i] = 1'b0;
        end
        clear_models();

        // Reset state
        #12;
        for (int i = 0; i < 3; i++) chk(i);
        check("rst_rd_data", 32'(rd_data[0]), 32'h00);
        check("rst_rd_valid", 32'(rd_valid[0]), 32'h0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Fill and drain, with an overflow attempt while full
        step(0, 1'b1, 8'h11, 1'b0, 1'b0);
        step(0, 1'b1, 8'h22, 1'b0, 1'b0);
        step(0, 1'b1, 8'h33, 1'b0, 1'b0);
        step(0, 1'b1, 8'h44, 1'b0, 1'b0);
        check("fill_full", 32'(full[0]), 32'h1);
        step(0, 1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_set", 32'(ovf[0]), 32'h1);
        check("ovf_count", 32'(count[0]), 32'd4);
        step(0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(ovf[0]), 32'h0);
        for (int k = 0; k < 4; k++) step(0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_last", 32'(rd_data[0]), 32'h44);
        check("drain_empty", 32'(empty[0]), 32'h1);
        check("drain_count", 32'(count[0]), 32'd0);

        // Simultaneous write+read while full
        for (int k = 0; k < 4; k++) step(0, 1'b1, 8'hA1 + 8'(k), 1'b0, 1'b0);
        step(0, 1'b1, 8'hA5, 1'b1, 1'b0);
        check("full_rw_count", 32'(count[0]), 32'd4);
        for (int k = 0; k < 4; k++) step(0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("full_rw_last", 32'(rd_data[0]), 32'hA5);

        // Simultaneous write+read while empty
        step(0, 1'b1, 8'hB1, 1'b1, 1'b0);
        check("empty_rw_udf", 32'(udf[0]), 32'h1);
        check("empty_rw_count", 32'(count[0]), 32'd1);
        step(0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(0, 1'b1, 8'hB2, 1'b0, 1'b0);
        step(0, 1'b1, 8'hB3, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count[0]), 32'd3);

        // FWFT: head visible the cycle after the write, pop empties next cycle
        step(1, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("fwft_data", 32'(rd_data[1]), 32'hA5);
        check("fwft_vld", 32'(rd_valid[1]), 32'h1);
        step(1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_empty", 32'(empty[1]), 32'h1);
        step(1, 1'b1, 8'hC1, 1'b0, 1'b0);
        step(1, 1'b1, 8'hC2, 1'b1, 1'b0);
        step(1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1, 1'b0, 8'h00, 1'b1, 1'b1);

        // Thresholds and pointer wrap on the depth-5 instance (12 words)
        for (int k = 0; k < 4; k++) step(2, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) step(2, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 4; k < 7; k++) step(2, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
        check("th_full", 32'(full[2]), 32'h1);
        for (int k = 0; k < 5; k++) step(2, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 7; k < 12; k++) step(2, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(2, 1'b0, 8'h00, 1'b1, 1'b0);
        check("th_last", 32'(rd_data[2]), 32'h4B);

        // Asynchronous reset between edges with three words held
        @(negedge clk); #1 rst = 1'b0;
        #1;
        check("arst_empty", 32'(empty[0]), 32'h1);
        check("arst_count", 32'(count[0]), 32'd0);
        check("arst_vld", 32'(rd_valid[0]), 32'h0);
        clear_models();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        step(0, 1'b1, 8'hE1, 1'b0, 1'b0);
        step(0, 1'b1, 8'hE2, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_first", 32'(rd_data[0]), 32'hE1);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) check($sformatf("sb_left[%0d]", i), exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
